// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier: one N+1 bit add/sub stage reused
// over N iterations, start/busy/done handshake, product held until the next completion.

module RCA #(
   parameter int W = 33
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         sub,
   output logic [W-1:0] sum
);
   logic [W-1:0] b_x;
   logic         carry;

   assign b_x = B ^ {W{sub}};

   always_comb begin
      sum   = '0;
      carry = sub;
      for (int i = 0; i < W; i++) begin
         sum[i] = A[i] ^ b_x[i] ^ carry;
         carry  = (A[i] & b_x[i]) | (carry & (A[i] ^ b_x[i]));
      end
   end
endmodule

// State table:
//   IDLE | waiting for start, operands sampled on the accepting edge
//   ITER | one Booth step per cycle, busy high
//   DONE | product valid, done pulses for this single cycle
module booth_mult_seq #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [N:0]    a;
   logic [N:0]    m;
   logic [N-1:0]  q;
   logic          q_m1;
   logic [CW-1:0] count;

   logic          rca_sub;
   logic [N:0]    rca_sum;
   logic [N:0]    t;

   // Adder output is only taken on a 01/10 bit pair; otherwise A passes through.
   assign rca_sub = q[0] & ~q_m1;
   assign t       = (q[0] ^ q_m1) ? rca_sum : a;
   assign busy    = (state == ITER);

   RCA #(.W(N + 1)) u_rca (
      .A   (a),
      .B   (m),
      .sub (rca_sub),
      .sum (rca_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a       <= '0;
         m       <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  m     <= {multiplicand[N-1], multiplicand};
                  a     <= '0;
                  q     <= multiplier;
                  q_m1  <= 1'b0;
                  count <= CW'(N);
                  state <= ITER;
               end
            end
            ITER: begin
               a     <= {t[N], t[N:1]};
               q     <= {t[0], q[N-1:1]};
               q_m1  <= q[0];
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  // Post-shift {A[N-1:0], Q} written directly from T and Q.
                  product <= {t[N:0], q[N-1:1]};
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (N = 32): handshake timing, signed
// corner products, ignored starts, async reset abort and back-to-back use.

module tb_booth_mult_seq;
   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   multiplicand = '0;
   logic [N-1:0]   multiplier = '0;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int total = 0;
   int bad = 0;

   booth_mult_seq #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      longint sx;
      longint sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   // Pulse start for one edge, then watch N+5 cycles. Cycle 1 is the one right
   // after the accepting edge; first_done is the cycle in which done is first seen.
   task automatic run_mul(input logic [31:0] x, input logic [31:0] y,
                          output int first_done, output int busy_cycles, output int done_cycles);
      first_done  = 0;
      busy_cycles = 0;
      done_cycles = 0;
      @(posedge clk); #1;
      multiplicand = x;
      multiplier   = y;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 1; j <= N + 5; j++) begin
         if (j > 1) begin
            @(posedge clk); #1;
         end
         if (busy) busy_cycles++;
         if (done) begin
            done_cycles++;
            if (first_done == 0) first_done = j;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b product=%h, want 0/0/0", busy, done, product);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int fd, bc, dc;
      run_mul(32'd3, 32'd5, fd, bc, dc);
      total++;
      if (product !== 64'd15) begin
         bad++;
         $display("FAIL basic_product: got %h want %h", product, 64'd15);
      end
      total++;
      if (fd !== N + 1) begin
         bad++;
         $display("FAIL basic_latency: done in cycle %0d want %0d", fd, N + 1);
      end
      total++;
      if (bc !== N) begin
         bad++;
         $display("FAIL basic_busy_len: got %0d want %0d", bc, N);
      end
      total++;
      if (dc !== 1) begin
         bad++;
         $display("FAIL basic_done_pulses: got %0d want 1", dc);
      end
   endtask

   task automatic test_signed();
      int fd, bc, dc;
      run_mul(-32'sd7, 32'd6, fd, bc, dc);
      total++;
      if (product !== 64'hFFFF_FFFF_FFFF_FFD6) begin
         bad++;
         $display("FAIL signed_m7x6: got %h want %h", product, 64'hFFFF_FFFF_FFFF_FFD6);
      end
      run_mul(32'd6, -32'sd7, fd, bc, dc);
      total++;
      if (product !== 64'hFFFF_FFFF_FFFF_FFD6) begin
         bad++;
         $display("FAIL signed_6xm7: got %h want %h", product, 64'hFFFF_FFFF_FFFF_FFD6);
      end
   endtask

   task automatic test_corners();
      int fd, bc, dc;
      run_mul(32'h8000_0000, 32'h8000_0000, fd, bc, dc);
      total++;
      if (product !== 64'h4000_0000_0000_0000) begin
         bad++;
         $display("FAIL corner_min_sq: got %h want %h", product, 64'h4000_0000_0000_0000);
      end
      run_mul(32'h8000_0000, 32'hFFFF_FFFF, fd, bc, dc);
      total++;
      if (product !== 64'h0000_0000_8000_0000) begin
         bad++;
         $display("FAIL corner_min_x_m1: got %h want %h", product, 64'h0000_0000_8000_0000);
      end
   endtask

   task automatic test_random();
      int fd, bc, dc;
      logic [31:0] x, y;
      logic [63:0] exp_p;
      for (int k = 0; k < 8; k++) begin
         x = $urandom;
         y = $urandom;
         if (k == 0) x = 32'h7FFF_FFFF;
         if (k == 1) y = 32'h8000_0000;
         if (k == 2) x = 32'd0;
         exp_p = ref_mul(x, y);
         run_mul(x, y, fd, bc, dc);
         total++;
         if (product !== exp_p || fd !== N + 1 || dc !== 1) begin
            bad++;
            $display("FAIL random_%0d: %h*%h got %h (done@%0d x%0d) want %h (done@%0d x1)",
                     k, x, y, product, fd, dc, exp_p, N + 1);
         end
      end
   endtask

   task automatic test_start_ignored();
      int fd, bc, dc;
      fd = 0;
      dc = 0;
      @(posedge clk); #1;
      multiplicand = 32'd12;
      multiplier   = 32'd12;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 1; j <= N + 5; j++) begin
         if (j > 1) begin
            @(posedge clk); #1;
         end
         if (j == 10) begin
            multiplicand = 32'd2;
            multiplier   = 32'd2;
            start        = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dc++;
            if (fd == 0) fd = j;
         end
      end
      total++;
      if (product !== 64'd144) begin
         bad++;
         $display("FAIL ignored_start_product: got %h want %h", product, 64'd144);
      end
      total++;
      if (dc !== 1 || fd !== N + 1) begin
         bad++;
         $display("FAIL ignored_start_done: got %0d pulses first@%0d want 1 @%0d", dc, fd, N + 1);
      end
      run_mul(32'd2, 32'd2, fd, bc, dc);
      total++;
      if (product !== 64'd4) begin
         bad++;
         $display("FAIL fresh_after_ignored: got %h want %h", product, 64'd4);
      end
   endtask

   task automatic test_async_reset();
      int fd, bc, dc;
      int dseen;
      dseen = 0;
      @(posedge clk); #1;
      multiplicand = 32'h0123_4567;
      multiplier   = 32'h089A_BCDE;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      total++;
      if (busy !== 1'b1 || product !== 64'd4) begin
         bad++;
         $display("FAIL iter_hold: got busy=%b product=%h want busy=1 product=%h", busy, product, 64'd4);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         bad++;
         $display("FAIL async_reset: got busy=%b done=%b product=%h want 0/0/0", busy, done, product);
      end
      repeat (3) begin
         @(posedge clk); #1;
         if (done) dseen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 2) begin
         @(posedge clk); #1;
         if (done) dseen++;
      end
      total++;
      if (dseen !== 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL aborted_no_done: got %0d done pulses busy=%b want 0 pulses busy=0", dseen, busy);
      end
      run_mul(32'd0, 32'h7FFF_FFFF, fd, bc, dc);
      total++;
      if (product !== 64'd0 || dc !== 1) begin
         bad++;
         $display("FAIL post_reset_zero: got %h pulses=%0d want 0 pulses=1", product, dc);
      end
   endtask

   task automatic test_back_to_back();
      int waited;
      logic [31:0] x2, y2;
      logic [63:0] exp2;
      x2 = $urandom;
      y2 = $urandom;
      exp2 = ref_mul(x2, y2);
      @(posedge clk); #1;
      multiplicand = 32'h7FFF_FFFF;
      multiplier   = 32'h7FFF_FFFF;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      waited = 0;
      while (!done && waited < N + 10) begin
         @(posedge clk); #1;
         waited++;
      end
      total++;
      if (!done || product !== 64'h3FFF_FFFF_0000_0001) begin
         bad++;
         $display("FAIL b2b_first: got done=%b product=%h want 1/%h", done, product, 64'h3FFF_FFFF_0000_0001);
      end
      @(posedge clk); #1;
      multiplicand = x2;
      multiplier   = y2;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_accept: got busy=%b want 1", busy);
      end
      waited = 0;
      while (!done && waited < N + 10) begin
         @(posedge clk); #1;
         waited++;
      end
      total++;
      if (!done || product !== exp2) begin
         bad++;
         $display("FAIL b2b_second: %h*%h got done=%b product=%h want 1/%h", x2, y2, done, product, exp2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_corners();
      test_random();
      test_start_ignored();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
